// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the instruction funct-to-op decode.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // Returns {valid, op}; valid is low for functs that do not use this unit.
  function automatic logic [3:0] funct_to_op(input logic [5:0] funct);
    case (funct)
      FUNCT_MULT:  return {1'b1, MD_MULT};
      FUNCT_MULTU: return {1'b1, MD_MULTU};
      FUNCT_DIV:   return {1'b1, MD_DIV};
      FUNCT_DIVU:  return {1'b1, MD_DIVU};
      FUNCT_MTHI:  return {1'b1, MD_MTHI};
      FUNCT_MTLO:  return {1'b1, MD_MTLO};
      default:     return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/mult_div_unit_compute.sv
// Combinational result generator: 64-bit {hi,lo} pending value for an op,
// including signed/unsigned handling and the divide-by-zero hold rule.
module md_compute
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic               overflow;

  always_comb begin
    sa       = {{32{a[31]}}, a};
    sb       = {{32{b[31]}}, b};
    // Most-negative / -1 wraps back to the dividend rather than trapping.
    overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sq       = '0;
    sr       = '0;
    if (overflow) begin
      sq = $signed(a);
    end else if (b != '0) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
    end

    result = {hi, lo};
    case (op)
      MD_MULT:  result = sa * sb;
      MD_MULTU: result = {32'b0, a} * {32'b0, b};
      MD_DIV:   if (b != '0) result = {sr, sq};
      MD_DIVU:  if (b != '0) result = {a % b, a / b};
      default:  result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning architectural HI/LO; busy is
// held for a fixed latency and the result commits as busy drops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)
(
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  md_state_e        next_state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] next_counter;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      phi;
  logic [31:0]      plo;
  logic [63:0]      result;
  logic             load_pending;
  logic             commit;
  logic             write_hi;
  logic             write_lo;

  md_compute u_compute (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (result)
  );

  always_comb begin
    next_state   = state;
    next_counter = counter;
    load_pending = 1'b0;
    commit       = 1'b0;
    write_hi     = 1'b0;
    write_lo     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MD_MULT, MD_MULTU: begin
              next_state   = ST_MUL;
              next_counter = CNT_W'(MULT_CYCLES);
              load_pending = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              next_state   = ST_DIV;
              next_counter = CNT_W'(DIV_CYCLES);
              load_pending = 1'b1;
            end
            MD_MTHI: write_hi = 1'b1;
            MD_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        // Requests arriving here are ignored; the pipeline must stall on busy.
        if (counter == CNT_W'(1)) begin
          commit       = 1'b1;
          next_state   = ST_IDLE;
          next_counter = '0;
        end else begin
          next_counter = counter - CNT_W'(1);
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi     <= '0;
      plo     <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
      if (load_pending) {phi, plo} <= result;
      if (commit) begin
        hi_q <= phi;
        lo_q <= plo;
      end
      if (write_hi) hi_q <= bus.a;
      if (write_lo) lo_q <= bus.a;
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// checked against an arithmetic model of HI/LO and the busy latency.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_N     = 5;
  localparam int DIV_N      = 10;
  localparam int WAIT_LIMIT = 100;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit_if md_if ();

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (md_if)
  );

  always #5 clk = ~clk;

  // Reference model: applies an op to m_hi/m_lo and returns the expected busy length.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    lat = 0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MD_MULT: begin
        p = sa * sb;
        m_hi = p[63:32]; m_lo = p[31:0]; lat = MULT_N;
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; lat = MULT_N;
      end
      MD_DIV: begin
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        lat = DIV_N;
      end
      MD_DIVU: begin
        if (b != 0) begin
          m_lo = a / b; m_hi = a % b;
        end
        lat = DIV_N;
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: lat = 0;
    endcase
  endtask

  // Called at a negedge; drives a one-cycle start strobe and returns at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.a     = a;
    md_if.b     = b;
    @(negedge clk);
    md_if.start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles, output bit stable);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = md_if.hi;
    l0 = md_if.lo;
    cycles = 0;
    stable = 1'b1;
    while (md_if.busy === 1'b1 && cycles < WAIT_LIMIT) begin
      cycles++;
      if (md_if.hi !== h0 || md_if.lo !== l0) stable = 1'b0;
      @(negedge clk);
    end
    if (md_if.busy !== 1'b0) cycles = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    md_if.start = 1'b0;
    md_if.op = '0;
    md_if.a = '0;
    md_if.b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (md_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%0b expected=0", md_if.busy); end
    checks++;
    if (md_if.hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi actual=%h expected=0", md_if.hi); end
    checks++;
    if (md_if.lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo actual=%h expected=0", md_if.lo); end
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
  endtask

  task automatic run_table(input string name, input logic [2:0] ops[], input logic [31:0] as[],
                           input logic [31:0] bs[]);
    int lat, cycles;
    bit stable;
    for (int i = 0; i < ops.size(); i++) begin
      model_apply(ops[i], as[i], bs[i], lat);
      issue(ops[i], as[i], bs[i]);
      wait_idle(cycles, stable);
      checks++;
      if (cycles != lat) begin failures++; $display("[TB] FAIL %s_busy[%0d] actual=%0d expected=%0d", name, i, cycles, lat); end
      checks++;
      if (!stable) begin failures++; $display("[TB] FAIL %s_stable[%0d] actual=changed expected=stable", name, i); end
      checks++;
      if (md_if.hi !== m_hi) begin failures++; $display("[TB] FAIL %s_hi[%0d] actual=%h expected=%h", name, i, md_if.hi, m_hi); end
      checks++;
      if (md_if.lo !== m_lo) begin failures++; $display("[TB] FAIL %s_lo[%0d] actual=%h expected=%h", name, i, md_if.lo, m_lo); end
    end
  endtask

  task automatic test_mult();
    logic [2:0]  ops[] = '{MD_MULT, MD_MULTU, MD_MULT};
    logic [31:0] as[]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs[]  = '{32'h2, 32'h2, 32'h8000_0000};
    run_table("mult", ops, as, bs);
  endtask

  task automatic test_div();
    logic [2:0]  ops[] = '{MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
    logic [31:0] as[]  = '{32'hFFFF_FFF9, 32'h7, 32'h8000_0000, 32'h7};
    logic [31:0] bs[]  = '{32'h2, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    run_table("div", ops, as, bs);
  endtask

  task automatic test_mthi_div_zero();
    int lat, cycles;
    bit stable;
    model_apply(MD_MTHI, 32'h1234, 32'h0, lat);
    issue(MD_MTHI, 32'h1234, 32'h0);
    checks++;
    if (md_if.hi !== m_hi) begin failures++; $display("[TB] FAIL mthi_hi actual=%h expected=%h", md_if.hi, m_hi); end
    checks++;
    if (md_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL mthi_busy actual=%0b expected=0", md_if.busy); end
    model_apply(MD_DIV, 32'h5, 32'h0, lat);
    issue(MD_DIV, 32'h5, 32'h0);
    wait_idle(cycles, stable);
    checks++;
    if (cycles != lat) begin failures++; $display("[TB] FAIL divzero_busy actual=%0d expected=%0d", cycles, lat); end
    checks++;
    if (md_if.hi !== m_hi) begin failures++; $display("[TB] FAIL divzero_hi actual=%h expected=%h", md_if.hi, m_hi); end
    checks++;
    if (md_if.lo !== m_lo) begin failures++; $display("[TB] FAIL divzero_lo actual=%h expected=%h", md_if.lo, m_lo); end
  endtask

  task automatic test_reset_abort();
    int  lat;
    bit  changed;
    model_apply(MD_MULT, 32'h0001_2345, 32'h0000_0777, lat);
    issue(MD_MULT, 32'h0001_2345, 32'h0000_0777);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    checks++;
    if (md_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy actual=%0b expected=0", md_if.busy); end
    checks++;
    if (md_if.hi !== m_hi || md_if.lo !== m_lo) begin
      failures++; $display("[TB] FAIL abort_hilo actual=%h_%h expected=%h_%h", md_if.hi, md_if.lo, m_hi, m_lo);
    end
    @(negedge clk);
    reset = 1'b1;
    changed = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (md_if.busy !== 1'b0 || md_if.hi !== m_hi || md_if.lo !== m_lo) changed = 1'b1;
    end
    checks++;
    if (changed) begin failures++; $display("[TB] FAIL abort_no_commit actual=changed expected=quiet"); end
  endtask

  task automatic test_start_while_busy();
    int lat, cycles;
    bit stable;
    model_apply(MD_MULT, 32'h0000_1234, 32'h0000_5678, lat);
    issue(MD_MULT, 32'h0000_1234, 32'h0000_5678);
    if (md_if.busy === 1'b1) $display("[TB] note: protocol violation, start issued while busy");
    issue(MD_MTLO, 32'h0000_AAAA, 32'h0);
    wait_idle(cycles, stable);
    checks++;
    if (cycles != lat - 1) begin failures++; $display("[TB] FAIL busy_ignore_len actual=%0d expected=%0d", cycles, lat - 1); end
    checks++;
    if (md_if.lo !== m_lo) begin failures++; $display("[TB] FAIL busy_ignore_lo actual=%h expected=%h", md_if.lo, m_lo); end
    checks++;
    if (md_if.hi !== m_hi) begin failures++; $display("[TB] FAIL busy_ignore_hi actual=%h expected=%h", md_if.hi, m_hi); end
  endtask

  task automatic test_unused_op();
    int lat;
    for (int op = 6; op < 8; op++) begin
      model_apply(3'(op), $urandom, $urandom, lat);
      issue(3'(op), $urandom, $urandom);
      checks++;
      if (md_if.busy !== 1'b0 || md_if.hi !== m_hi || md_if.lo !== m_lo) begin
        failures++;
        $display("[TB] FAIL unused_op%0d actual=%0b_%h_%h expected=0_%h_%h", op, md_if.busy, md_if.hi, md_if.lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_random();
    int          lat, cycles, sel;
    bit          stable;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 5));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 16));
      model_apply(op, a, b, lat);
      issue(op, a, b);
      if (lat == 0) begin
        checks++;
        if (md_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL rand_busy[%0d] actual=%0b expected=0", i, md_if.busy); end
      end else begin
        wait_idle(cycles, stable);
        checks++;
        if (cycles != lat) begin failures++; $display("[TB] FAIL rand_len[%0d] op=%0d actual=%0d expected=%0d", i, op, cycles, lat); end
        checks++;
        if (!stable) begin failures++; $display("[TB] FAIL rand_stable[%0d] actual=changed expected=stable", i); end
      end
      checks++;
      if (md_if.hi !== m_hi || md_if.lo !== m_lo) begin
        failures++;
        $display("[TB] FAIL rand_hilo[%0d] op=%0d a=%h b=%h actual=%h_%h expected=%h_%h",
                 i, op, a, b, md_if.hi, md_if.lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_div_zero();
    test_reset_abort();
    test_start_while_busy();
    test_unused_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide responder in the EX stage; owns architectural HI/LO.
- Accepts an operation from the pipeline, raises busy for a fixed latency, then commits results to HI/LO.
- The pipeline stall logic consumes busy (and start) to hold MD/MFHI/MFLO/MTHI/MTLO instructions in ID.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request strobe from EX, sampled on rising clk
op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO
a  input  32  operand rs (already forwarded)
b  input  32  operand rt (already forwarded)
busy  output  1  unit occupied; high while an MD operation is in flight
hi  output  32  architectural HI register
lo  output  32  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, hi=0, lo=0, counter=0, pending regs=0. Reset during an operation aborts it. No commit occurs.
- FSM states: IDLE, MUL, DIV.
- IDLE + start + op MULT/MULTU:
  - Latch the 64-bit product into pending {phi,plo}. MULT is signed 32x32, MULTU is unsigned.
  - Load counter with MULT_CYCLES; go to MUL.
- IDLE + start + op DIV/DIVU:
  - b != 0: latch quotient into plo and remainder into phi. DIV truncates toward zero and the remainder takes the dividend's sign; DIVU is unsigned.
  - b == 0: latch pending = current {hi,lo} so the commit leaves HI/LO unchanged.
  - Load counter with DIV_CYCLES; go to DIV.
- IDLE + start + MTHI: hi <= a at that edge; busy stays 0.
- IDLE + start + MTLO: lo <= a at that edge; busy stays 0.
- MUL/DIV: busy=1.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1: hi <= phi, lo <= plo, state goes to IDLE, busy drops.
  - busy is therefore high for exactly N cycles, starting the cycle after start. New HI/LO are visible in the first cycle busy=0.
- start while busy=1 (any op) is ignored and state is unaffected. This is a protocol violation; the bench flags it, the RTL does not.
- Unused op codes with start: no effect.
- hi/lo are stable and do not change while busy=1. They change only on MTHI/MTLO or on commit.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap). No exception is raised.
- busy is registered (no combinational path from start). The core must stall on (start | busy).

Decomposition:
- Shared package/include: op encoding constants MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; FSM state constants.
- The same include provides decode macros mapping instruction funct to op.
- One natural sub-module, md_compute: purely combinational. Takes op, a, b, and current hi/lo; produces the 64-bit pending result, including the signed/unsigned and divide-by-zero rules.
- mult_div_unit holds the FSM, counter and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 -> busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- MTHI a=0x1234, then DIV a=5, b=0 -> hi=0x1234 immediately; after 10 busy cycles hi/lo are unchanged.
- MULT started, reset pulsed low at busy cycle 3 -> busy=0, hi=lo=0 immediately; no later commit.
- Start with MTLO a=0xAAAA issued during a busy MULT -> ignored; lo afterwards equals the product low word only.
